// File: rtl/debounce_sync.sv
// Debouncer: synchronizes a raw asynchronous input, then commits a new level only
// after it has been stable for STABLE_CYCLES synchronized clocks. Emits edge pulses.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000,
  parameter int   CNT_W         = 16,
  parameter logic INIT          = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       d,
  output logic       q,
  output logic       qn,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam state_e           ST_RESET = INIT ? ST_HIGH : ST_LOW;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ds;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   qn_q, qn_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  assign ds = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (ds) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!ds) begin
          // Bounce: abandon the candidate edge without touching q.
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!ds) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (ds) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
    qn_d   = ~q_d;
    busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q  <= {SYNC_STAGES{INIT}};
      state_q <= ST_RESET;
      cnt_q   <= '0;
      q_q     <= INIT;
      qn_q    <= ~INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q         = q_q;
  assign qn        = qn_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4; a second
// instance with INIT=1 covers the alternate reset value.
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       d = 1'b0;
  logic       q, qn, rise, fall, busy;
  logic [1:0] dbg_state;
  logic       d_b = 1'b1;
  logic       q_b, qn_b, rise_b, fall_b, busy_b;
  logic [1:0] dbg_state_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(16), .INIT(1'b0)) dut (
    .clk(clk), .clr(clr), .d(d), .q(q), .qn(qn), .rise(rise), .fall(fall),
    .busy(busy), .dbg_state(dbg_state)
  );

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(16), .INIT(1'b1)) dut_b (
    .clk(clk), .clr(clr), .d(d_b), .q(q_b), .qn(qn_b), .rise(rise_b), .fall(fall_b),
    .busy(busy_b), .dbg_state(dbg_state_b)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eq, input logic er,
                         input logic ef, input logic eb);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_qn"}, qn, ~eq);
    chk({tag, "_rise"}, rise, er);
    chk({tag, "_fall"}, fall, ef);
    chk({tag, "_busy"}, busy, eb);
  endtask

  initial begin
    // Reset, two edges
    clr = 1'b1; d = 1'b0; d_b = 1'b1;
    step(); step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_b_q", q_b, 1'b1);
    chk("reset_b_qn", qn_b, 1'b0);
    chk("reset_b_rise", rise_b, 1'b0);
    chk("reset_b_fall", fall_b, 1'b0);
    chk("reset_b_busy", busy_b, 1'b0);
    clr = 1'b0;
    step(); step();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean rise: edge 1 is the first edge sampling d=1
    d = 1'b1;
    step(); chk_all("rise_e1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rise_e2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rise_e3", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("rise_e4", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("rise_e5", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("rise_e6", 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_all("rise_e7", 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rise_e8", 1'b1, 1'b0, 1'b0, 1'b0);

    // Clean fall
    d = 1'b0;
    step(); chk_all("fall_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("fall_e2", 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("fall_e3", 1'b1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("fall_e4", 1'b1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("fall_e5", 1'b1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("fall_e6", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("fall_e7", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();

    // Bounce: d=1 for 3 edges only, one sample short of a commit
    d = 1'b1;
    step(); chk_all("bnc_e1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("bnc_e2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("bnc_e3", 1'b0, 1'b0, 1'b0, 1'b1);
    d = 1'b0;
    step(); chk_all("bnc_e4", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("bnc_e5", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("bnc_e6", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("bnc_e7", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("bnc_e8", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh rise after the bounce commits exactly on edge 6
    d = 1'b1;
    step(); chk_all("rr_e1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rr_e2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rr_e3", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("rr_e4", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("rr_e5", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("rr_e6", 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_all("rr_e7", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset from q=1 returns to INIT
    clr = 1'b1; d = 1'b0;
    step();
    chk_all("clr_hi", 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    step(); step();

    // Reset mid-qualification: clr sampled on edge 4 while in WAIT_HIGH
    d = 1'b1;
    step(); step();
    step(); chk_all("mid_e3", 1'b0, 1'b0, 1'b0, 1'b1);
    clr = 1'b1;
    step(); chk_all("mid_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    step(); chk_all("mid_r1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("mid_r2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("mid_r3", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("mid_r4", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("mid_r5", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("mid_r6", 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_all("mid_r7", 1'b1, 1'b0, 1'b0, 1'b0);

    // Toggling input: q holds, no pulses, qn tracks ~q
    clr = 1'b1; d = 1'b0;
    step();
    clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = ~d;
      step();
      chk("tog_q", q, 1'b0);
      chk("tog_qn", qn, ~q);
      chk("tog_rise", rise, 1'b0);
      chk("tog_fall", fall, 1'b0);
    end

    // INIT=1 instance held d=1 throughout and must never have moved
    chk("b_hold_q", q_b, 1'b1);
    chk("b_hold_qn", qn_b, 1'b0);
    chk("b_hold_fall", fall_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
